arm_operand_shifter: RTL and testbench

//  Operand-2 stage directly upstream of the data-processing ALU. It takes a decoded data-processing

---
 rtl/arm_operand_shifter_pkg.sv | 52 +++++
 rtl/arm_barrel_shift.sv | 121 ++++++++++++
 rtl/arm_operand_shifter.sv | 157 +++++++++++++++
 tb/tb_arm_operand_shifter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_operand_shifter_pkg.sv
// Shared definitions for the operand-2 stage: opcodes, CPSR bit positions,
// instruction field positions, shift types and the stage FSM states.
package arm_operand_shifter_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int unsigned CPSR_N = 31;
    localparam int unsigned CPSR_Z = 30;
    localparam int unsigned CPSR_C = 29;
    localparam int unsigned CPSR_V = 28;

    localparam int unsigned INSTR_I     = 25;
    localparam int unsigned INSTR_S     = 20;
    localparam int unsigned INSTR_REGSH = 4;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RS_WAIT = 1'b1
    } state_t;

    // Fields held across the Rs read cycle of a register-specified shift.
    typedef struct packed {
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  op;
        logic        s;
        logic [1:0]  sh_type;
    } pend_t;

endpackage

// File: rtl/arm_barrel_shift.sv
// Combinational ARM barrel shifter covering both the immediate-amount encoding
// (with its #0 special meanings) and the register-amount encoding (0..255).
module arm_barrel_shift
    import arm_operand_shifter_pkg::*;
(
    input  logic [31:0] value,
    input  logic [7:0]  amount,
    input  logic [1:0]  sh_type,
    input  logic        carry_in,
    input  logic        imm_form,
    output logic [31:0] result,
    output logic        carry_out
);

    logic [4:0]  amt5;
    logic [4:0]  idx_l;
    logic [4:0]  idx_r;
    logic [31:0] lsl_v;
    logic [31:0] lsr_v;
    logic [31:0] asr_v;
    logic [31:0] ror_v;
    logic [31:0] sign_v;

    assign amt5   = amount[4:0];
    // For 1..31, 32-amt and amt-1 both fit in 5 bits, so wrap-around is harmless.
    assign idx_l  = 5'd0 - amt5;
    assign idx_r  = amt5 - 5'd1;
    assign lsl_v  = value << amt5;
    assign lsr_v  = value >> amt5;
    assign asr_v  = $signed(value) >>> amt5;
    assign ror_v  = lsr_v | (value << idx_l);
    assign sign_v = {32{value[31]}};

    always_comb begin
        result    = value;
        carry_out = carry_in;
        if (imm_form) begin
            case (shift_t'(sh_type))
                SH_LSL: begin
                    if (amt5 != 5'd0) begin
                        result    = lsl_v;
                        carry_out = value[idx_l];
                    end
                end
                SH_LSR: begin
                    if (amt5 == 5'd0) begin
                        result    = '0;
                        carry_out = value[31];
                    end else begin
                        result    = lsr_v;
                        carry_out = value[idx_r];
                    end
                end
                SH_ASR: begin
                    if (amt5 == 5'd0) begin
                        result    = sign_v;
                        carry_out = value[31];
                    end else begin
                        result    = asr_v;
                        carry_out = value[idx_r];
                    end
                end
                SH_ROR: begin
                    if (amt5 == 5'd0) begin
                        result    = {carry_in, value[31:1]};
                        carry_out = value[0];
                    end else begin
                        result    = ror_v;
                        carry_out = value[idx_r];
                    end
                end
            endcase
        end else if (amount != 8'd0) begin
            case (shift_t'(sh_type))
                SH_LSL: begin
                    if (amount < 8'd32) begin
                        result    = lsl_v;
                        carry_out = value[idx_l];
                    end else if (amount == 8'd32) begin
                        result    = '0;
                        carry_out = value[0];
                    end else begin
                        result    = '0;
                        carry_out = 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amount < 8'd32) begin
                        result    = lsr_v;
                        carry_out = value[idx_r];
                    end else if (amount == 8'd32) begin
                        result    = '0;
                        carry_out = value[31];
                    end else begin
                        result    = '0;
                        carry_out = 1'b0;
                    end
                end
                SH_ASR: begin
                    if (amount < 8'd32) begin
                        result    = asr_v;
                        carry_out = value[idx_r];
                    end else begin
                        result    = sign_v;
                        carry_out = value[31];
                    end
                end
                SH_ROR: begin
                    if (amt5 == 5'd0) begin
                        result    = value;
                        carry_out = value[31];
                    end else begin
                        result    = ror_v;
                        carry_out = value[idx_r];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_operand_shifter.sv
// Operand-2 stage ahead of the data-processing ALU: handshake, Rs-wait FSM and
// output registers around the barrel shifter.
module arm_operand_shifter
    import arm_operand_shifter_pkg::*;
#(
    parameter bit RS_LATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rn_val,
    input  logic [31:0] rm_val,
    input  logic [31:0] rs_val,
    input  logic        cpsr_c,
    output logic        rs_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_op_sel,
    output logic        s_bit,
    output logic        shift_carry
);

    state_t      state;
    state_t      state_next;
    pend_t       pend;
    logic        accept;
    logic        reg_shift;
    logic        load_out;
    logic        go_wait;
    logic [31:0] sh_value;
    logic [7:0]  sh_amount;
    logic [1:0]  sh_type;
    logic        sh_imm_form;
    logic [31:0] sh_result;
    logic        sh_carry;
    logic [31:0] op1_src;
    logic [3:0]  op_src;
    logic        s_src;
    logic        unused_bits;

    assign unused_bits = ^{instr[31:26], instr[19:12], instr[3:0], rs_val[31:8]};

    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign reg_shift = !instr[INSTR_I] && instr[INSTR_REGSH];
    assign rs_req    = (state == ST_RS_WAIT);

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        go_wait    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (reg_shift && RS_LATE) begin
                        state_next = ST_RS_WAIT;
                        go_wait    = 1'b1;
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            ST_RS_WAIT: begin
                state_next = ST_IDLE;
                load_out   = 1'b1;
            end
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            load_out   = 1'b0;
        end
    end

    // In RS_WAIT the shifter runs on the held Rn/Rm/opcode with the live Rs
    // and CPSR.C; otherwise it runs directly on the presented instruction.
    always_comb begin
        sh_value    = rm_val;
        sh_amount   = {3'b000, instr[11:7]};
        sh_type     = instr[6:5];
        sh_imm_form = 1'b1;
        op1_src     = rn_val;
        op_src      = instr[24:21];
        s_src       = instr[INSTR_S];
        if (state == ST_RS_WAIT) begin
            sh_value    = pend.rm;
            sh_amount   = rs_val[7:0];
            sh_type     = pend.sh_type;
            sh_imm_form = 1'b0;
            op1_src     = pend.rn;
            op_src      = pend.op;
            s_src       = pend.s;
        end else if (instr[INSTR_I]) begin
            sh_value    = {24'h000000, instr[7:0]};
            sh_amount   = {3'b000, instr[11:8], 1'b0};
            sh_type     = SH_ROR;
            sh_imm_form = 1'b0;
        end else if (instr[INSTR_REGSH]) begin
            sh_amount   = rs_val[7:0];
            sh_imm_form = 1'b0;
        end
    end

    arm_barrel_shift u_shift (
        .value     (sh_value),
        .amount    (sh_amount),
        .sh_type   (sh_type),
        .carry_in  (cpsr_c),
        .imm_form  (sh_imm_form),
        .result    (sh_result),
        .carry_out (sh_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (go_wait) begin
            pend <= '{rn: rn_val, rm: rm_val, op: instr[24:21], s: instr[INSTR_S],
                      sh_type: instr[6:5]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            alu_op_sel  <= '0;
            s_bit       <= 1'b0;
            shift_carry <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_out) begin
            out_valid   <= 1'b1;
            alu_op1     <= op1_src;
            alu_op2     <= sh_result;
            alu_op_sel  <= op_src;
            s_bit       <= s_src;
            shift_carry <= sh_carry;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arm_operand_shifter.sv
// Bench for arm_operand_shifter: directed literal cases plus randomized traffic
// checked every cycle against a bit-serial shift model and handshake model.
module tb_arm_operand_shifter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [31:0] rs_val;
    logic        cpsr_c;
    logic        rs_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_op_sel;
    logic        s_bit;
    logic        shift_carry;

    int total = 0;
    int bad   = 0;

    arm_operand_shifter #(.RS_LATE(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rn_val      (rn_val),
        .rm_val      (rm_val),
        .rs_val      (rs_val),
        .cpsr_c      (cpsr_c),
        .rs_req      (rs_req),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_op_sel  (alu_op_sel),
        .s_bit       (s_bit),
        .shift_carry (shift_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Shift one bit at a time; carry is whatever bit fell off last.
    function automatic void model_shift(input logic [31:0] ins, input logic [31:0] rm,
                                        input logic [7:0] rsb, input logic c,
                                        output logic [31:0] res, output logic co);
        logic [31:0] v;
        logic [1:0]  ty;
        int unsigned n;
        co = c;
        ty = ins[6:5];
        if (ins[25]) begin
            v  = {24'h0, ins[7:0]};
            ty = 2'b11;
            n  = 2 * int'(ins[11:8]);
        end else begin
            v = rm;
            n = ins[4] ? int'(rsb) : int'(ins[11:7]);
            if (!ins[4] && n == 0) begin
                if (ty == 2'b01 || ty == 2'b10) n = 32;
                if (ty == 2'b11) begin
                    res = {c, rm[31:1]};
                    co  = rm[0];
                    return;
                end
            end
        end
        for (int unsigned i = 0; i < n; i++) begin
            case (ty)
                2'b00: begin co = v[31]; v = v << 1; end
                2'b01: begin co = v[0];  v = v >> 1; end
                2'b10: begin co = v[0];  v = {v[31], v[31:1]}; end
                default: begin co = v[0]; v = {v[0], v[31:1]}; end
            endcase
        end
        res = v;
    endfunction

    // Handshake model state: what the output registers should hold right now.
    logic        m_valid = 1'b0;
    logic        m_wait  = 1'b0;
    logic [31:0] m_op1, m_op2;
    logic [3:0]  m_sel;
    logic        m_s, m_c;
    logic [31:0] p_ins, p_rn, p_rm;
    logic        m_rdy;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_wait  = 1'b0;
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_rs_req", {31'b0, rs_req}, 32'd0);
        end else begin
            m_rdy = !m_wait && (!m_valid || out_ready);
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
            chk("rs_req", {31'b0, rs_req}, {31'b0, m_wait});
            if (m_valid) begin
                chk("alu_op1", alu_op1, m_op1);
                chk("alu_op2", alu_op2, m_op2);
                chk("alu_op_sel", {28'b0, alu_op_sel}, {28'b0, m_sel});
                chk("s_bit", {31'b0, s_bit}, {31'b0, m_s});
                chk("shift_carry", {31'b0, shift_carry}, {31'b0, m_c});
            end
            if (flush) begin
                m_valid = 1'b0;
                m_wait  = 1'b0;
            end else if (m_wait) begin
                model_shift(p_ins, p_rm, rs_val[7:0], cpsr_c, m_op2, m_c);
                m_op1   = p_rn;
                m_sel   = p_ins[24:21];
                m_s     = p_ins[20];
                m_valid = 1'b1;
                m_wait  = 1'b0;
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (in_valid && m_rdy) begin
                    if (!instr[25] && instr[4]) begin
                        p_ins  = instr;
                        p_rn   = rn_val;
                        p_rm   = rm_val;
                        m_wait = 1'b1;
                    end else begin
                        model_shift(instr, rm_val, rs_val[7:0], cpsr_c, m_op2, m_c);
                        m_op1   = rn_val;
                        m_sel   = instr[24:21];
                        m_s     = instr[20];
                        m_valid = 1'b1;
                    end
                end
            end
        end
    end

    task automatic direct(input string nm, input logic [31:0] ins, input logic [31:0] rm,
                          input logic [31:0] rs, input logic c, input logic [31:0] e2,
                          input logic ec, input int el);
        int  lat;
        int  rq;
        bit  ok;
        @(posedge clk); #1;
        in_valid = 1'b1; instr = ins; rn_val = $urandom; rm_val = rm; rs_val = rs;
        cpsr_c = c; out_ready = 1'b1; flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        chk({nm, "_accept"}, {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1'b0; lat = 0; rq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (rs_req) rq++;
            if (out_valid) begin ok = 1'b1; break; end
        end
        chk({nm, "_done"}, {31'b0, ok}, 32'd1);
        chk({nm, "_latency"}, 32'(lat), 32'(el));
        chk({nm, "_rs_req_cycles"}, 32'(rq), (el == 2) ? 32'd1 : 32'd0);
        chk({nm, "_op2"}, alu_op2, e2);
        chk({nm, "_carry"}, {31'b0, shift_carry}, {31'b0, ec});
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; rn_val = '0;
        rm_val = '0; rs_val = '0; cpsr_c = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_op1", alu_op1, 32'd0);
        chk("reset_op2", alu_op2, 32'd0);
        chk("reset_sel", {28'b0, alu_op_sel}, 32'd0);
        chk("reset_sbit_carry", {30'b0, s_bit, shift_carry}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        direct("imm_rot",  32'hE3B004FF, 32'h0,        32'h0,        1'b1, 32'hFF000000, 1'b1, 1);
        direct("lsr0",     32'hE1B00020, 32'h80000001, 32'h0,        1'b0, 32'h00000000, 1'b1, 1);
        direct("rrx",      32'hE1B00060, 32'h80000001, 32'h0,        1'b0, 32'h40000000, 1'b1, 1);
        direct("rlsl33",   32'hE1B00210, 32'hFFFFFFFF, 32'd33,       1'b1, 32'h00000000, 1'b0, 2);
        direct("rlsl32",   32'hE1B00210, 32'hFFFFFFFF, 32'd32,       1'b0, 32'h00000000, 1'b1, 2);
        direct("rror32",   32'hE1B00270, 32'h80000000, 32'h20,       1'b0, 32'h80000000, 1'b1, 2);
        direct("rror0",    32'hE1B00270, 32'h80000000, 32'h0,        1'b0, 32'h80000000, 1'b0, 2);
        direct("rlsr_hi",  32'hE1B00230, 32'h00000003, 32'hABCDEF01, 1'b0, 32'h00000001, 1'b1, 2);

        // Back-pressure: hold out_ready low for three cycles with a second op waiting.
        @(posedge clk); #1;
        in_valid = 1'b1; instr = 32'hE3B004FF; out_ready = 1'b0; cpsr_c = 1'b1;
        @(negedge clk);
        chk("stall_first_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        instr = 32'hE3B00001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_op2", alu_op2, 32'hFF000000);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("release_next_valid", {31'b0, out_valid}, 32'd1);
        chk("release_next_op2", alu_op2, 32'h00000001);
        chk("release_next_carry", {31'b0, shift_carry}, 32'd1);

        // Flush while waiting on Rs.
        @(posedge clk); #1;
        in_valid = 1'b1; instr = 32'hE1B00210; rm_val = 32'hFFFFFFFF; rs_val = 32'd4;
        @(negedge clk);
        chk("flush_pre_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_rs_wait", {31'b0, rs_req}, 32'd1);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_rs_req", {31'b0, rs_req}, 32'd0);
        @(negedge clk);
        chk("flush_stays_empty", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a register-shift op.
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_rs_req", {31'b0, rs_req}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_op1", alu_op1, 32'd0);
        chk("midrst_op2", alu_op2, 32'd0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 29) == 0);
            cpsr_c    = $urandom_range(0, 1);
            instr     = $urandom;
            if ($urandom_range(0, 3) == 0) instr[11:7] = 5'd0;
            rn_val    = $urandom;
            rm_val    = $urandom;
            rs_val    = $urandom;
            case ($urandom_range(0, 3))
                0: rs_val[7:0] = 8'($urandom_range(0, 40));
                1: rs_val[7:0] = 8'd32;
                2: rs_val[7:0] = 8'd0;
                default: ;
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
